// File: rtl/sonic_echo_responder.sv
// sonic_echo_responder: responder side of the HC-SR04 trig/echo protocol.
// Takes a trigger pulse, waits the burst delay, then raises echo for a width set by distance_cm.
// Ports: clk, rst (async active-low), trig (async pin), distance_cm/obj_valid (obstacle model),
//        echo (registered pulse), busy (not IDLE), short_trig (1-cycle rejected-trigger flag).
module sonic_echo_responder #(
   parameter int TICKS_PER_US   = 100,
   parameter int TRIG_MIN_US    = 10,
   parameter int BURST_DELAY_US = 250,
   parameter int US_PER_CM      = 58,
   parameter int MIN_CM         = 2,
   parameter int MAX_CM         = 400,
   parameter int TIMEOUT_US     = 38000,
   parameter int HOLDOFF_US     = 10000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       trig,
   input  logic [8:0] distance_cm,
   input  logic       obj_valid,
   output logic       echo,
   output logic       busy,
   output logic       short_trig
);

   localparam int HI_MIN = TRIG_MIN_US * TICKS_PER_US;
   localparam int PW     = (TICKS_PER_US > 1) ? $clog2(TICKS_PER_US) : 1;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      TRIG_HI = 3'd1,
      BURST   = 3'd2,
      ECHO    = 3'd3,
      HOLDOFF = 3'd4
   } state_t;

   state_t          state;
   state_t          state_nx;
   logic            trig_m;
   logic            trig_s;
   logic            trig_p;
   logic [PW-1:0]   pre;
   logic [15:0]     us_cnt;
   logic [15:0]     hi_cnt;
   logic [15:0]     width_us;
   logic [15:0]     width_nx;
   logic            pre_wrap;
   logic            hi_ok;

   assign pre_wrap = (pre == PW'(TICKS_PER_US - 1));
   assign hi_ok    = (hi_cnt >= 16'(HI_MIN));

   // Two-flop synchronizer; trig_p is the previous synchronized sample for edge detection.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         trig_m <= 1'b0;
         trig_s <= 1'b0;
         trig_p <= 1'b0;
      end else begin
         trig_m <= trig;
         trig_s <= trig_m;
         trig_p <= trig_s;
      end
   end

   // Echo width in microseconds from the current obstacle inputs.
   always_comb begin
      width_nx = 16'(TIMEOUT_US);
      if (!obj_valid || (distance_cm > 9'(MAX_CM)))
         width_nx = 16'(TIMEOUT_US);
      else if (distance_cm < 9'(MIN_CM))
         width_nx = 16'(MIN_CM * US_PER_CM);
      else
         width_nx = 16'(32'(distance_cm) * 32'(US_PER_CM));
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (trig_s && !trig_p) state_nx = TRIG_HI;
         TRIG_HI: if (!trig_s) state_nx = hi_ok ? BURST : IDLE;
         BURST:   if (pre_wrap && (us_cnt == 16'(BURST_DELAY_US - 1))) state_nx = ECHO;
         ECHO:    if (pre_wrap && (us_cnt == width_us - 16'd1)) state_nx = HOLDOFF;
         HOLDOFF: if (pre_wrap && (us_cnt == 16'(HOLDOFF_US - 1))) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         state <= IDLE;
      else
         state <= state_nx;
   end

   // Timebase restarts on every state change so each phase lasts an exact cycle count.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pre    <= '0;
         us_cnt <= '0;
      end else if (state_nx != state) begin
         pre    <= '0;
         us_cnt <= '0;
      end else if (pre_wrap) begin
         pre    <= '0;
         us_cnt <= us_cnt + 16'd1;
      end else begin
         pre    <= pre + PW'(1);
      end
   end

   // High-width counter: the sample that triggered entry counts as the first high cycle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hi_cnt <= '0;
      end else if ((state == IDLE) && (state_nx == TRIG_HI)) begin
         hi_cnt <= 16'd1;
      end else if ((state == TRIG_HI) && trig_s && !hi_ok) begin
         hi_cnt <= hi_cnt + 16'd1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         width_us <= '0;
      else if ((state == TRIG_HI) && (state_nx == BURST))
         width_us <= width_nx;
   end

   // Outputs are registered from the next state so they line up with the state register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         echo       <= 1'b0;
         busy       <= 1'b0;
         short_trig <= 1'b0;
      end else begin
         echo       <= (state_nx == ECHO);
         busy       <= (state_nx != IDLE);
         short_trig <= (state == TRIG_HI) && (state_nx == IDLE);
      end
   end

endmodule

// File: tb/tb_sonic_echo_responder.sv
// Testbench for sonic_echo_responder with scaled-down timing parameters:
// 4 clk/us, 40-cycle min trigger, 100-cycle burst, 3 us/cm, 1500 us timeout, 800-cycle holdoff.
// Directed steps in one initial block; a monitor timestamps echo/busy edges and short_trig pulses.
module tb_sonic_echo_responder;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       trig = 1'b0;
   logic [8:0] distance_cm = 9'd0;
   logic       obj_valid = 1'b1;
   logic       echo;
   logic       busy;
   logic       short_trig;

   always #5 clk = ~clk;

   sonic_echo_responder #(
      .TICKS_PER_US(4), .TRIG_MIN_US(10), .BURST_DELAY_US(25), .US_PER_CM(3),
      .MIN_CM(2), .MAX_CM(400), .TIMEOUT_US(1500), .HOLDOFF_US(200)
   ) dut (
      .clk(clk), .rst(rst), .trig(trig), .distance_cm(distance_cm),
      .obj_valid(obj_valid), .echo(echo), .busy(busy), .short_trig(short_trig)
   );

   int errors = 0;
   int checks = 0;

   int   cyc = 0;
   logic echo_q = 1'b0;
   logic busy_q = 1'b0;
   int   n_er = 0, n_ef = 0, n_br = 0, n_bf = 0, n_short = 0;
   int   t_er = 0, t_ef = 0, t_br = 0, t_bf = 0, t_sh = 0;

   always @(posedge clk) begin
      #1;
      cyc++;
      if (echo && !echo_q) begin n_er++; t_er = cyc; end
      if (!echo && echo_q) begin n_ef++; t_ef = cyc; end
      if (busy && !busy_q) begin n_br++; t_br = cyc; end
      if (!busy && busy_q) begin n_bf++; t_bf = cyc; end
      if (short_trig) begin n_short++; t_sh = cyc; end
      echo_q = echo;
      busy_q = busy;
   end

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // One trigger of p cycles; waits (bounded) for busy to fall and reports the timings.
   task automatic run(input int p, input int d, input logic v,
                      output int lat, output int wid, output int hold, output int bw);
      int e0, b0;
      e0 = n_er;
      b0 = n_bf;
      distance_cm = 9'(d);
      obj_valid = v;
      trig = 1'b1;
      cycles(p);
      trig = 1'b0;
      for (int i = 0; i < 20000 && n_bf == b0; i++) cycles(1);
      if (n_er != e0) begin
         lat = t_er - t_br; wid = t_ef - t_er; hold = t_bf - t_ef;
      end else begin
         lat = -1; wid = -1; hold = -1;
      end
      bw = (n_bf != b0) ? (t_bf - t_br) : -1;
      cycles(5);
   endtask

   initial begin
      int lat, wid, hold, bw, s0, e0, b0, f0;

      // Reset held while trig toggles.
      for (int i = 0; i < 5; i++) begin
         trig = ~trig;
         cycles(1);
         chk("reset_outputs", int'({echo, busy, short_trig}), 0);
      end
      trig = 1'b0;
      cycles(3);
      rst = 1'b1;
      cycles(5);

      // Nominal 20 cm: burst 100 + trig 100, width 60us*4, holdoff 800.
      s0 = n_short;
      run(100, 20, 1'b1, lat, wid, hold, bw);
      chk("nom_latency", lat, 200);
      chk("nom_width", wid, 240);
      chk("nom_holdoff", hold, 800);
      chk("nom_busy_total", bw, 1240);
      chk("nom_no_short", n_short - s0, 0);

      // Short triggers: 20 and 39 cycles rejected, 40 accepted.
      s0 = n_short; e0 = n_er;
      run(20, 20, 1'b1, lat, wid, hold, bw);
      chk("short20_busy", bw, 20);
      chk("short20_pulses", n_short - s0, 1);
      chk("short20_pulse_time", t_sh - t_br, 20);
      chk("short20_no_echo", n_er - e0, 0);
      s0 = n_short;
      run(39, 20, 1'b1, lat, wid, hold, bw);
      chk("short39_busy", bw, 39);
      chk("short39_pulses", n_short - s0, 1);
      s0 = n_short;
      run(40, 20, 1'b1, lat, wid, hold, bw);
      chk("min40_latency", lat, 140);
      chk("min40_width", wid, 240);
      chk("min40_no_short", n_short - s0, 0);

      // Range limits.
      run(100, 450, 1'b1, lat, wid, hold, bw);
      chk("far450_width", wid, 6000);
      run(100, 401, 1'b1, lat, wid, hold, bw);
      chk("far401_width", wid, 6000);
      run(100, 20, 1'b0, lat, wid, hold, bw);
      chk("noobj_width", wid, 6000);
      run(100, 1, 1'b1, lat, wid, hold, bw);
      chk("near1_width", wid, 24);
      run(100, 0, 1'b1, lat, wid, hold, bw);
      chk("near0_width", wid, 24);
      run(100, 2, 1'b1, lat, wid, hold, bw);
      chk("min2_width", wid, 24);
      run(100, 400, 1'b1, lat, wid, hold, bw);
      chk("max400_width", wid, 4800);
      chk("max400_holdoff", hold, 800);

      // Retrigger during ECHO and HOLDOFF, distance changed mid-echo.
      s0 = n_short; b0 = n_br; e0 = n_er; f0 = n_ef;
      distance_cm = 9'd20; obj_valid = 1'b1;
      trig = 1'b1; cycles(100); trig = 1'b0;
      for (int i = 0; i < 1000 && n_er == e0; i++) cycles(1);
      cycles(50);
      trig = 1'b1; cycles(60); trig = 1'b0;
      distance_cm = 9'd100;
      for (int i = 0; i < 1000 && n_ef == f0; i++) cycles(1);
      cycles(100);
      trig = 1'b1; cycles(60); trig = 1'b0;
      f0 = n_bf;
      for (int i = 0; i < 2000 && n_bf == f0; i++) cycles(1);
      chk("retrig_width", t_ef - t_er, 240);
      chk("retrig_no_short", n_short - s0, 0);
      chk("retrig_one_busy", n_br - b0, 1);
      cycles(20);
      chk("retrig_idle_after", int'(busy), 0);

      // Trigger held high across the end of HOLDOFF.
      b0 = n_br; f0 = n_ef;
      distance_cm = 9'd20;
      trig = 1'b1; cycles(100); trig = 1'b0;
      for (int i = 0; i < 1000 && n_ef == f0; i++) cycles(1);
      cycles(100);
      trig = 1'b1;
      f0 = n_bf;
      for (int i = 0; i < 2000 && n_bf == f0; i++) cycles(1);
      cycles(50);
      chk("held_no_new_meas", n_br - b0, 1);
      chk("held_busy_low", int'(busy), 0);
      trig = 1'b0;
      cycles(10);
      run(100, 20, 1'b1, lat, wid, hold, bw);
      chk("held_fresh_width", wid, 240);

      // Reset 3000 cycles into a long echo.
      e0 = n_er;
      distance_cm = 9'd450;
      trig = 1'b1; cycles(100); trig = 1'b0;
      for (int i = 0; i < 1000 && n_er == e0; i++) cycles(1);
      chk("rst_echo_started", n_er - e0, 1);
      cycles(3000);
      rst = 1'b0;
      #1;
      chk("rst_echo_async", int'(echo), 0);
      chk("rst_busy_async", int'(busy), 0);
      cycles(3);
      rst = 1'b1;
      cycles(3);
      run(100, 20, 1'b1, lat, wid, hold, bw);
      chk("post_rst_latency", lat, 200);
      chk("post_rst_width", wid, 240);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/sonic_echo_responder.md
# sonic_echo_responder

Synthesizable model of the HC-SR04 ultrasonic ranger, the responder side of the trig/echo protocol driven by the car's sonic ranging block. It accepts a trigger pulse, waits the acoustic burst time, then drives `echo` high for a width proportional to a programmed obstacle distance. It is used for on-board loopback and hardware-in-the-loop tests of the car's stop logic without a physical sensor.

## Interface
Parameters:
- `TICKS_PER_US`, 100: clk cycles per microsecond (100 MHz).
- `TRIG_MIN_US`, 10: minimum valid trigger high width.
- `BURST_DELAY_US`, 250: delay from accepted trigger fall to echo rise.
- `US_PER_CM`, 58: echo width per centimetre.
- `MIN_CM`, 2: distances below this are clamped up to it.
- `MAX_CM`, 400: distances above this produce the timeout echo.
- `TIMEOUT_US`, 38000: echo width for no object or out of range.
- `HOLDOFF_US`, 10000: dead time after echo falls.

Ports:
- `clk` input 1: system clock.
- `rst` input 1: asynchronous, active-low reset.
- `trig` input 1: trigger from the initiator (asynchronous; synchronized internally).
- `distance_cm` input 9: simulated obstacle distance.
- `obj_valid` input 1: 0 means no obstacle, which forces the timeout echo.
- `echo` output 1: echo pulse, registered.
- `busy` output 1: high in every state except IDLE.
- `short_trig` output 1: one-cycle pulse when a trigger shorter than TRIG_MIN_US is rejected.

## Operation
- `trig` passes through a 2-FF synchronizer to give `trig_s`. All edges below refer to `trig_s`.
- Timebase: a prescaler counts 0..TICKS_PER_US-1 and a µs counter increments on each prescaler wrap. Both clear on every state entry, so every duration is exact in clk cycles.
- States:
  - IDLE: `trig_s` rising enters TRIG_HI.
  - TRIG_HI: counts high cycles, saturating at TRIG_MIN_US·TICKS_PER_US. On `trig_s`=0:
    - If the count reached the minimum, latch the distance and go to BURST.
    - Otherwise pulse `short_trig` and return to IDLE.
  - BURST: after BURST_DELAY_US, go to ECHO.
  - ECHO: `echo`=1 for the latched width W µs, then go to HOLDOFF.
  - HOLDOFF: after HOLDOFF_US, go to IDLE.
- Width W is computed from `distance_cm` and `obj_valid` sampled on the cycle TRIG_HI exits:
  - If `obj_valid`=0 or `distance_cm`>MAX_CM: W=TIMEOUT_US.
  - Else if `distance_cm`<MIN_CM: W=MIN_CM·US_PER_CM.
  - Else: W=`distance_cm`·US_PER_CM.
  - The product is 15 bits max (400·58=23200); W is held in a 16-bit register.
- Triggers in BURST, ECHO and HOLDOFF are ignored entirely: no state change and no `short_trig`. A trigger still high when HOLDOFF ends is not accepted; IDLE requires a fresh rising edge.
- Changes to `distance_cm` or `obj_valid` after latching have no effect on the measurement in progress.
- Reset (`rst`=0, any state, including mid-echo): state goes to IDLE; `echo`, `busy`, `short_trig`, synchronizer, counters and W all clear to 0 immediately. Operation resumes on the first clk edge after `rst` deasserts.

## Timing
- Synchronizer latency is 2 cycles. TRIG_HI is entered on the 3rd clk edge after `trig` rises at the pin.
- The high-width count uses synchronized samples, so the accepted width equals the pin width ±1 cycle.
- BURST is entered on the edge after `trig_s` falls.
- `echo` rises exactly BURST_DELAY_US·TICKS_PER_US cycles after BURST entry.
- `echo` stays high exactly W·TICKS_PER_US cycles.
- `busy` goes high in the same cycle TRIG_HI is entered. It goes low HOLDOFF_US·TICKS_PER_US cycles after `echo` falls.
- `short_trig` is high for exactly the single cycle on which TRIG_HI exits to IDLE.
- All outputs are registered. Reset values: `echo`=0, `busy`=0, `short_trig`=0.

## Test plan
Run the bench with TICKS_PER_US=10; all cycle counts below are at that setting.
- **Reset:** hold `rst`=0 for 5 cycles while `trig` toggles -> `echo`=0, `busy`=0, `short_trig`=0 throughout.
- **Nominal:** `trig` high 100 cycles, `distance_cm`=20, `obj_valid`=1 -> `echo` rises 2500 cycles after BURST entry and is high for exactly 11600 cycles; `busy` drops 100000 cycles after `echo` falls.
- **Short trigger:** `trig` high 50 cycles -> one `short_trig` pulse, `echo` stays 0, `busy` returns to 0 on the same cycle.
- **Range limits:**
  - `distance_cm`=450 -> `echo` 380000 cycles.
  - `obj_valid`=0 -> `echo` 380000 cycles.
  - `distance_cm`=1 -> `echo` 1160 cycles.
  - `distance_cm`=400 -> `echo` 232000 cycles.
- **Retrigger and input change:**
  - Pulse `trig` during ECHO and during HOLDOFF, and change `distance_cm` to 100 mid-ECHO -> echo width unchanged at 11600 cycles, no `short_trig`.
  - Hold `trig` high across the end of HOLDOFF -> no new measurement until `trig` falls and rises again.
- **Reset mid-echo:** assert `rst` 3000 cycles into ECHO -> `echo` and `busy` fall without waiting for a clk edge; after release, a valid trigger gives a normal 11600-cycle echo.
